// File: rtl/ram_port_arbiter.sv
// Shares one BRAM read port between two KCPSM3 requesters.
// Each requester posts a read address, polls a status byte, then fetches the captured data byte.
module ram_port_arbiter #(
   parameter logic [7:0] ADDR_PORT   = 8'h00,
   parameter logic [7:0] STATUS_PORT = 8'h01,
   parameter logic [7:0] DATA_PORT   = 8'h02
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id_1,
   input  logic [7:0] port_id_2,
   input  logic       write_strobe_1,
   input  logic       write_strobe_2,
   input  logic       read_strobe_1,
   input  logic       read_strobe_2,
   input  logic [7:0] out_port_1,
   input  logic [7:0] out_port_2,
   output logic [7:0] in_port_1,
   output logic [7:0] in_port_2,
   output logic [7:0] ram_address,
   output logic       ram_en,
   input  logic [7:0] ram_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t     state, state_nxt;
   logic       grant_q;       // requester in service: 0 = requester 1, 1 = requester 2
   logic       last_grant_q;
   logic       grant_go;
   logic       grant_sel;

   logic [7:0] pid   [2];
   logic [7:0] wdata [2];
   logic [7:0] rdata [2];
   logic [1:0] wstb;
   logic [1:0] rstb;

   logic [7:0] addr_q [2];
   logic [7:0] data_q [2];
   logic [1:0] pending_q;
   logic [1:0] ready_q;
   logic [1:0] overrun_q;

   logic [1:0] in_service;
   logic [1:0] addr_wr;
   logic [1:0] accept;
   logic [1:0] drop;
   logic [1:0] status_rd;
   logic [1:0] data_rd;
   logic [1:0] capture;

   assign pid[0]    = port_id_1;
   assign pid[1]    = port_id_2;
   assign wdata[0]  = out_port_1;
   assign wdata[1]  = out_port_2;
   assign wstb      = {write_strobe_2, write_strobe_1};
   assign rstb      = {read_strobe_2, read_strobe_1};
   assign in_port_1 = rdata[0];
   assign in_port_2 = rdata[1];

   // Per-requester strobe decode
   always_comb begin
      in_service = '0;
      addr_wr    = '0;
      accept     = '0;
      drop       = '0;
      status_rd  = '0;
      data_rd    = '0;
      capture    = '0;
      for (int n = 0; n < 2; n++) begin
         in_service[n] = (state != IDLE) && (grant_q == n[0]);
         addr_wr[n]    = wstb[n] && (pid[n] == ADDR_PORT);
         accept[n]     = addr_wr[n] && !pending_q[n] && !in_service[n];
         drop[n]       = addr_wr[n] && !accept[n];
         status_rd[n]  = rstb[n] && (pid[n] == STATUS_PORT);
         data_rd[n]    = rstb[n] && (pid[n] == DATA_PORT);
         capture[n]    = (state == CAPTURE) && (grant_q == n[0]);
      end
   end

   always_comb begin
      for (int n = 0; n < 2; n++) begin
         rdata[n] = 8'h00;
         if (pid[n] == DATA_PORT)
            rdata[n] = data_q[n];
         else if (pid[n] == STATUS_PORT)
            rdata[n] = {5'b00000, overrun_q[n], pending_q[n] | in_service[n], ready_q[n]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Grant only looks at registered pending, so a request posted this cycle waits one cycle
   always_comb begin
      state_nxt = state;
      grant_go  = 1'b0;
      grant_sel = 1'b0;
      case (state)
         IDLE: begin
            if (pending_q[0] && pending_q[1]) begin
               grant_go  = 1'b1;
               grant_sel = ~last_grant_q;
            end else if (pending_q[0]) begin
               grant_go  = 1'b1;
               grant_sel = 1'b0;
            end else if (pending_q[1]) begin
               grant_go  = 1'b1;
               grant_sel = 1'b1;
            end
            if (grant_go)
               state_nxt = ISSUE;
         end
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ram_address only moves on the IDLE->ISSUE edge; ram_en covers the single ISSUE cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_address  <= 8'h00;
         ram_en       <= 1'b0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         ram_en <= 1'b0;
         if (state == IDLE && grant_go) begin
            ram_address <= grant_sel ? addr_q[1] : addr_q[0];
            ram_en      <= 1'b1;
            grant_q     <= grant_sel;
         end
         if (state == CAPTURE)
            last_grant_q <= grant_q;
      end
   end

   // Later assignments win: capture overrides a DATA read clearing ready in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < 2; n++) begin
            addr_q[n] <= 8'h00;
            data_q[n] <= 8'h00;
         end
         pending_q <= '0;
         ready_q   <= '0;
         overrun_q <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (accept[n]) begin
               addr_q[n]    <= wdata[n];
               pending_q[n] <= 1'b1;
               ready_q[n]   <= 1'b0;
            end
            if (drop[n])
               overrun_q[n] <= 1'b1;
            else if (status_rd[n])
               overrun_q[n] <= 1'b0;
            if (data_rd[n])
               ready_q[n] <= 1'b0;
            if (capture[n]) begin
               data_q[n]    <= ram_out;
               ready_q[n]   <= 1'b1;
               pending_q[n] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: BRAM model, issue-order and data scoreboards, table plus directed sequences.
module tb_ram_port_arbiter;

   localparam logic [7:0] ADDR_PORT   = 8'h00;
   localparam logic [7:0] STATUS_PORT = 8'h01;
   localparam logic [7:0] DATA_PORT   = 8'h02;
   localparam logic [7:0] IDLE_PORT   = 8'hFF;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] port_id_1 = IDLE_PORT, port_id_2 = IDLE_PORT;
   logic       write_strobe_1 = 1'b0, write_strobe_2 = 1'b0;
   logic       read_strobe_1 = 1'b0, read_strobe_2 = 1'b0;
   logic [7:0] out_port_1 = 8'h00, out_port_2 = 8'h00;
   logic [7:0] in_port_1, in_port_2;
   logic [7:0] ram_address;
   logic       ram_en;
   logic [7:0] ram_out;

   always #10 clk = ~clk;

   ram_port_arbiter #(
      .ADDR_PORT(ADDR_PORT),
      .STATUS_PORT(STATUS_PORT),
      .DATA_PORT(DATA_PORT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .port_id_1(port_id_1),
      .port_id_2(port_id_2),
      .write_strobe_1(write_strobe_1),
      .write_strobe_2(write_strobe_2),
      .read_strobe_1(read_strobe_1),
      .read_strobe_2(read_strobe_2),
      .out_port_1(out_port_1),
      .out_port_2(out_port_2),
      .in_port_1(in_port_1),
      .in_port_2(in_port_2),
      .ram_address(ram_address),
      .ram_en(ram_en),
      .ram_out(ram_out)
   );

   logic [7:0] mem [256];
   always @(posedge clk) if (ram_en) ram_out <= mem[ram_address];

   typedef struct {
      int         n;
      logic [7:0] addr;
      logic [7:0] data;
      int         lat;
   } vec_t;
   vec_t vecs [5];

   int         checks = 0;
   int         errors = 0;
   logic [7:0] iss_q [$];
   logic [7:0] exp_q1 [$];
   logic [7:0] exp_q2 [$];
   logic       mon_en = 1'b0;
   logic       prev_en = 1'b0;
   logic [7:0] prev_addr = 8'h00;

   function automatic logic [7:0] exp_byte(input logic [7:0] a);
      return (a == 8'h10) ? 8'hA5 : (a ^ 8'h3C);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h required=%02h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; the negedge in between watches the BRAM port
   task automatic cyc();
      logic [7:0] e;
      @(negedge clk);
      if (mon_en) begin
         if (ram_en) begin
            chk_int("ram_en_single_cycle", int'(prev_en), 0);
            checks++;
            if (iss_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue actual=%02h required=none t=%0t", ram_address, $time);
            end else begin
               e = iss_q.pop_front();
               checks--;
               chk("issue_addr", ram_address, e);
            end
         end
         if (ram_address !== prev_addr)
            chk_int("addr_moves_only_on_issue", int'(ram_en), 1);
      end
      prev_en   = ram_en;
      prev_addr = ram_address;
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int n, input logic [7:0] pid, input logic ws, input logic rs,
                      input logic [7:0] od);
      if (n == 0) begin
         port_id_1 = pid; write_strobe_1 = ws; read_strobe_1 = rs; out_port_1 = od;
      end else begin
         port_id_2 = pid; write_strobe_2 = ws; read_strobe_2 = rs; out_port_2 = od;
      end
   endtask

   function automatic logic [7:0] inp(input int n);
      return (n == 0) ? in_port_1 : in_port_2;
   endfunction

   task automatic expect_req(input int n, input logic [7:0] a, input logic [7:0] d);
      iss_q.push_back(a);
      if (n == 0) exp_q1.push_back(d);
      else        exp_q2.push_back(d);
   endtask

   task automatic pop_chk(input int n, input logic [7:0] v);
      logic [7:0] e;
      if ((n == 0 && exp_q1.size() == 0) || (n == 1 && exp_q2.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL data_scoreboard_empty actual=%02h required=none", v);
      end else begin
         e = (n == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
         chk((n == 0) ? "data_1" : "data_2", v, e);
      end
   endtask

   task automatic p_write(input int n, input logic [7:0] pid, input logic [7:0] d);
      drv(n, pid, 1'b1, 1'b0, d);
      cyc();
      drv(n, IDLE_PORT, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic peek(input int n, input logic [7:0] pid, output logic [7:0] v);
      drv(n, pid, 1'b0, 1'b0, 8'h00);
      #1;
      v = inp(n);
   endtask

   task automatic p_read(input int n, input logic [7:0] pid, output logic [7:0] v);
      drv(n, pid, 1'b0, 1'b1, 8'h00);
      #1;
      v = inp(n);
      cyc();
      drv(n, IDLE_PORT, 1'b0, 1'b0, 8'h00);
   endtask

   // Cycles from now until ready_n reads 1; -1 if the budget runs out
   task automatic wait_ready(input int n, output int lat);
      logic [7:0] v;
      lat = -1;
      for (int k = 0; k < 12; k++) begin
         peek(n, STATUS_PORT, v);
         if (v[0]) begin
            lat = k;
            break;
         end
         cyc();
      end
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      reset  = 1'b1;
      cyc();
      reset  = 1'b0;
      cyc();
      mon_en = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] v;
      int lat;

      for (int i = 0; i < 256; i++) mem[i] = exp_byte(8'(i));
      vecs[0] = '{0, 8'h10, 8'hA5, 3};
      vecs[1] = '{1, 8'h44, 8'h78, 3};
      vecs[2] = '{0, 8'hFF, 8'hC3, 3};
      vecs[3] = '{1, 8'h00, 8'h3C, 3};
      vecs[4] = '{0, 8'h81, 8'hBD, 3};

      // Reset state
      @(posedge clk); #1;
      cyc();
      cyc();
      chk("rst_ram_en", {7'd0, ram_en}, 8'h00);
      chk("rst_ram_address", ram_address, 8'h00);
      peek(0, STATUS_PORT, v); chk("rst_status_1", v, 8'h00);
      peek(1, STATUS_PORT, v); chk("rst_status_2", v, 8'h00);
      peek(0, DATA_PORT, v);   chk("rst_data_1", v, 8'h00);
      peek(1, DATA_PORT, v);   chk("rst_data_2", v, 8'h00);
      reset = 1'b0;
      cyc();
      mon_en = 1'b1;

      // Single requests from the table
      for (int i = 0; i < 5; i++) begin
         expect_req(vecs[i].n, vecs[i].addr, vecs[i].data);
         p_write(vecs[i].n, ADDR_PORT, vecs[i].addr);
         peek(vecs[i].n, STATUS_PORT, v); chk("status_busy", v, 8'h02);
         wait_ready(vecs[i].n, lat);      chk_int("latency", lat, vecs[i].lat);
         peek(vecs[i].n, STATUS_PORT, v); chk("status_ready", v, 8'h01);
         p_read(vecs[i].n, DATA_PORT, v); pop_chk(vecs[i].n, v);
         peek(vecs[i].n, STATUS_PORT, v); chk("status_after_read", v, 8'h00);
         peek(vecs[i].n, DATA_PORT, v);   chk("data_retained", v, vecs[i].data);
      end

      // Tie after reset: requester 1 first, requester 2 one service later
      do_reset();
      expect_req(0, 8'h20, exp_byte(8'h20));
      expect_req(1, 8'h21, exp_byte(8'h21));
      drv(0, ADDR_PORT, 1'b1, 1'b0, 8'h20);
      drv(1, ADDR_PORT, 1'b1, 1'b0, 8'h21);
      cyc();
      drv(0, IDLE_PORT, 1'b0, 1'b0, 8'h00);
      drv(1, IDLE_PORT, 1'b0, 1'b0, 8'h00);
      peek(1, STATUS_PORT, v); chk("tie1_p2_waiting", v, 8'h02);
      wait_ready(0, lat); chk_int("tie1_p1_latency", lat, 3);
      wait_ready(1, lat); chk_int("tie1_p2_after_p1", lat, 3);
      p_read(0, DATA_PORT, v); pop_chk(0, v);
      p_read(1, DATA_PORT, v); pop_chk(1, v);

      // Requester 1 served alone, so the next tie goes to requester 2
      expect_req(0, 8'h22, exp_byte(8'h22));
      p_write(0, ADDR_PORT, 8'h22);
      wait_ready(0, lat); chk_int("solo_latency", lat, 3);
      p_read(0, DATA_PORT, v); pop_chk(0, v);
      expect_req(1, 8'h24, exp_byte(8'h24));
      expect_req(0, 8'h23, exp_byte(8'h23));
      drv(0, ADDR_PORT, 1'b1, 1'b0, 8'h23);
      drv(1, ADDR_PORT, 1'b1, 1'b0, 8'h24);
      cyc();
      drv(0, IDLE_PORT, 1'b0, 1'b0, 8'h00);
      drv(1, IDLE_PORT, 1'b0, 1'b0, 8'h00);
      wait_ready(1, lat); chk_int("tie2_p2_latency", lat, 3);
      wait_ready(0, lat); chk_int("tie2_p1_after_p2", lat, 3);
      p_read(1, DATA_PORT, v); pop_chk(1, v);
      p_read(0, DATA_PORT, v); pop_chk(0, v);

      // Overrun: second write one cycle later is dropped
      expect_req(1, 8'h30, exp_byte(8'h30));
      p_write(1, ADDR_PORT, 8'h30);
      p_write(1, ADDR_PORT, 8'h31);
      peek(1, STATUS_PORT, v);   chk("ovr_status_busy", v, 8'h06);
      wait_ready(1, lat);        chk_int("ovr_latency", lat, 2);
      peek(1, STATUS_PORT, v);   chk("ovr_status_ready", v, 8'h05);
      p_read(1, STATUS_PORT, v); chk("ovr_status_read", v, 8'h05);
      peek(1, STATUS_PORT, v);   chk("ovr_cleared", v, 8'h01);
      p_read(1, DATA_PORT, v);   pop_chk(1, v);

      // Unmapped ports
      p_read(0, 8'h7F, v); chk("unmapped_read", v, 8'h00);
      p_write(0, 8'h05, 8'h40);
      repeat (5) cyc();
      peek(0, STATUS_PORT, v); chk("unmapped_write_status", v, 8'h00);

      // Reset while ram_en is high
      p_write(0, ADDR_PORT, 8'h50);
      mon_en = 1'b0;
      cyc();
      chk("midreset_pre_en", {7'd0, ram_en}, 8'h01);
      chk("midreset_pre_addr", ram_address, 8'h50);
      reset = 1'b1;
      #1;
      chk("midreset_ram_en", {7'd0, ram_en}, 8'h00);
      chk("midreset_ram_address", ram_address, 8'h00);
      peek(0, STATUS_PORT, v); chk("midreset_status_1", v, 8'h00);
      peek(1, STATUS_PORT, v); chk("midreset_status_2", v, 8'h00);
      cyc();
      reset = 1'b0;
      cyc();
      mon_en = 1'b1;
      repeat (6) cyc();
      peek(0, STATUS_PORT, v); chk("midreset_no_late_ready", v, 8'h00);
      peek(0, DATA_PORT, v);   chk("midreset_no_capture", v, 8'h00);

      // Back-to-back: each new write right after the DATA read
      expect_req(0, 8'h60, exp_byte(8'h60));
      p_write(0, ADDR_PORT, 8'h60);
      for (int i = 0; i < 3; i++) begin
         wait_ready(0, lat); chk_int("b2b_latency", lat, 3);
         p_read(0, DATA_PORT, v); pop_chk(0, v);
         if (i < 2) begin
            expect_req(0, 8'h60 + 8'(17 * (i + 1)), exp_byte(8'h60 + 8'(17 * (i + 1))));
            p_write(0, ADDR_PORT, 8'h60 + 8'(17 * (i + 1)));
         end
      end

      // New request while ready is still set
      expect_req(0, 8'hA0, exp_byte(8'hA0));
      p_write(0, ADDR_PORT, 8'hA0);
      wait_ready(0, lat); chk_int("rdy_latency", lat, 3);
      peek(0, DATA_PORT, v); pop_chk(0, v);
      expect_req(0, 8'hB7, exp_byte(8'hB7));
      p_write(0, ADDR_PORT, 8'hB7);
      peek(0, STATUS_PORT, v); chk("rdy_cleared_by_write", v, 8'h02);
      wait_ready(0, lat); chk_int("rdy_second_latency", lat, 3);
      p_read(0, DATA_PORT, v); pop_chk(0, v);
      repeat (3) cyc();

      chk_int("issues_outstanding", iss_q.size(), 0);
      chk_int("data_1_outstanding", exp_q1.size(), 0);
      chk_int("data_2_outstanding", exp_q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_PORT, default 8'h00, port_id at which an OUTPUT latches a read address and posts a request.
REQ-002 Parameter STATUS_PORT, default 8'h01, port_id at which an INPUT returns the requester status byte.
REQ-003 Parameter DATA_PORT, default 8'h02, port_id at which an INPUT returns the captured RAM byte.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 port_id_1, port_id_2  input  8 each  KCPSM3 port_id of requester 1 / 2.
REQ-007 write_strobe_1, write_strobe_2  input  1 each  KCPSM3 write strobes.
REQ-008 read_strobe_1, read_strobe_2  input  1 each  KCPSM3 read strobes.
REQ-009 out_port_1, out_port_2  input  8 each  KCPSM3 output data.
REQ-010 in_port_1, in_port_2  output  8 each  KCPSM3 input data, combinational on port_id_n.
REQ-011 ram_address  output  8  registered BRAM read address.
REQ-012 ram_en  output  1  registered; high for exactly the cycle in which BRAM samples ram_address.
REQ-013 ram_out  input  8  BRAM read data, valid one clock edge after ram_address is sampled.

Function
REQ-014 Per requester n: addr_n (8b), data_n (8b), pending_n, ready_n, overrun_n flags.
REQ-015 write_strobe_n=1 with port_id_n==ADDR_PORT, pending_n=0 and not in service -> addr_n<=out_port_n, pending_n<=1, ready_n<=0.
REQ-016 Such a write while pending_n=1 or requester n in service -> dropped; addr_n unchanged; overrun_n<=1.
REQ-017 Write strobes to other port_ids -> ignored.
REQ-018 FSM states IDLE, ISSUE, CAPTURE; exactly one request in service at a time.
REQ-019 IDLE: no pending -> stay, ram_en=0. One pending -> grant it. Both pending -> grant the requester not equal to last_grant.
REQ-020 IDLE->ISSUE on grant: ram_address<=addr_g, ram_en<=1, grant register g latched.
REQ-021 ISSUE->CAPTURE unconditionally; ram_en<=0.
REQ-022 CAPTURE->IDLE unconditionally: data_g<=ram_out, ready_g<=1, pending_g<=0, last_grant<=g.
REQ-023 Latency: request accepted at edge E0 (unit idle) -> ram_en high E1..E2 -> ready_n=1 after E3; new grant possible at E4.
REQ-024 Request accepted in IDLE in the same cycle as the FSM evaluates the grant is not seen until the next cycle (pending is registered).
REQ-025 in_port_n = data_n when port_id_n==DATA_PORT; {5'b0, overrun_n, pending_n|in-service_n, ready_n} when port_id_n==STATUS_PORT; 8'h00 otherwise.
REQ-026 read_strobe_n=1 with port_id_n==DATA_PORT -> ready_n<=0; data_n retained.
REQ-027 read_strobe_n=1 with port_id_n==STATUS_PORT -> overrun_n<=0, unless a dropped write sets it in the same cycle (set wins).
REQ-028 DATA_PORT read while ready_n=0 -> returns current data_n, no state change.
REQ-029 New ADDR_PORT write while ready_n=1 -> accepted per REQ-015; ready_n cleared.
REQ-030 Requesters never stall; arbitration fairness: neither requester waits more than one service (3 cycles) behind the other.

Reset
REQ-031 reset=1 asynchronously forces FSM=IDLE, ram_address=8'h00, ram_en=0, all addr_n/data_n=8'h00, all flags 0, last_grant=2 (requester 1 wins first tie).
REQ-032 Reset asserted mid-service abandons the request; no ready is set and no data captured.

Verification
REQ-033 Single: P1 OUTPUT 8'h10 to ADDR_PORT, RAM[0x10]=8'hA5 -> ram_address=8'h10 with ram_en 1 cycle, STATUS_1=8'h01 3 cycles later, DATA_1=8'hA5, STATUS_1=8'h00 after read.
REQ-034 Tie: both write same cycle (P1 0x20, P2 0x21) after reset -> P1 served first, P2 ready exactly 3 cycles after P1; second tie -> P2 served first.
REQ-035 Overrun: P2 writes 0x30 then 0x31 one cycle later -> RAM[0x30] returned, STATUS_2 bit2=1, cleared by STATUS read.
REQ-036 Unmapped: P1 reads port 8'h7F -> in_port_1=8'h00; P1 writes port 8'h05 -> no ram_en pulse.
REQ-037 Reset mid-ISSUE: reset pulse while ram_en=1 -> all outputs 8'h00/0 immediately, STATUS_n=8'h00, no later ready.
REQ-038 Back-to-back: P1 three reads, each new write right after DATA read -> each returns the correct byte; ram_address never changes outside IDLE->ISSUE.
